// File: rtl/alu_pkg.sv
// Shared constants for the ALU-side functional units: widths, divider FSM
// encoding and the divide-by-zero quotient value.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [WIDTH-1:0] DBZ_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } div_state_t;

endpackage

// File: rtl/adder.sv
// 32-bit carry-lookahead adder: 4-bit groups with generate/propagate,
// group carries resolved by a second lookahead level.
module adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [7:0]  gg;
  logic [7:0]  pg;
  logic [8:0]  cg;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    pg = '0;
    cg = '0;
    c  = '0;
    for (int k = 0; k < 8; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      pg[k] = &p[4*k +: 4];
    end
    cg[0] = cin;
    for (int k = 0; k < 8; k++) begin
      cg[k+1] = gg[k] | (pg[k] & cg[k]);
    end
    // Carries inside each group come from the group's own carry-in.
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = cg[k];
      c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
    end
    sum  = p ^ c;
    cout = cg[8];
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock,
// using the datapath adder in subtract mode. start/done handshake.
module seq_divider #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import alu_pkg::*;

  // Handshake: start is sampled only in IDLE; done pulses for one cycle with
  // busy still high, and results hold from done until the next accepted start.
  div_state_t       state;
  div_state_t       state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CNT_W-1:0] cnt;

  logic             msb;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             ge;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last;

  assign {msb, r_sh} = {r_reg, q_reg[WIDTH-1]};

  adder u_adder (
    .a    (r_sh),
    .b    (~d_reg),
    .cin  (1'b1),
    .sum  (diff),
    .cout (cout)
  );

  // msb covers shifted remainders of 2^32 or more, which always exceed D.
  assign ge    = msb | cout;
  assign r_nxt = ge ? diff : r_sh;
  assign q_nxt = {q_reg[WIDTH-2:0], ge};
  assign last  = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (divisor == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      q_reg       <= '0;
      r_reg       <= '0;
      d_reg       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            q_reg       <= dividend;
            d_reg       <= divisor;
            r_reg       <= '0;
            cnt         <= '0;
            div_by_zero <= (divisor == '0);
            if (divisor == '0) begin
              quotient  <= DBZ_QUOTIENT;
              remainder <= dividend;
            end
          end
        end
        ST_RUN: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt + CNT_W'(1);
          // Publish on the final iteration so results line up with done.
          if (last) begin
            quotient  <= q_nxt;
            remainder <= r_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider: driver tasks issue divisions,
// a monitor pops expected {dbz, quotient, remainder} and done cycle on done.
module tb_seq_divider;

  localparam int W = 65;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           cyc;
  int           busy_run;
  int           n_checks;
  int           n_fail;

  seq_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain unsigned arithmetic, divide-by-zero convention.
  function automatic logic [W-1:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    q = a / b;
    r = a % b;
    return {1'b0, q, r};
  endfunction

  // driver tasks (called and returning at a negedge)
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int t;
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) check("issue_wait_idle", 32'(busy), 32'd0);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(ref_div(a, b));
    exp_cyc_q.push_back(cyc + 1 + ((b == 32'd0) ? 0 : 32));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    issue(a, b);
    wait_done();
  endtask

  // monitor / scoreboard
  initial busy_run = 0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    int           ec;
    if (busy) busy_run = busy_run + 1;
    else      busy_run = 0;
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(exp_q.size()), 32'd1);
      end else begin
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("quotient", quotient, e[63:32]);
        check("remainder", remainder, e[31:0]);
        check("div_by_zero", 32'(div_by_zero), 32'(e[64]));
        check("done_cycle", 32'(cyc), 32'(ec));
        check("busy_cycles", 32'(busy_run), e[64] ? 32'd1 : 32'd33);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          c0;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases, including the 33rd-bit path and boundaries
    run_op(32'd100, 32'd7);
    run_op(32'hFFFF_FFFF, 32'h8000_0000);
    run_op(32'hFFFF_FFFF, 32'd1);
    run_op(32'd5, 32'd0);
    run_op(32'd9, 32'd3);
    run_op(32'd7, 32'd100);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'd0, 32'd5);
    run_op(32'd12345, 32'd1);

    // start while busy is ignored
    issue(32'd1000, 32'd10);
    c0 = cyc;
    while (cyc < c0 + 9) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // asynchronous reset mid-operation
    @(negedge clk);
    issue(32'd1000, 32'd10);
    c0 = cyc;
    while (cyc < c0 + 14) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_quotient", quotient, 32'd0);
    check("arst_remainder", remainder, 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(32'd64, 32'd8);

    // randomised operands across operand-shape classes
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = $urandom_range(1, 255); end
        2: begin a = $urandom_range(0, 1000); b = $urandom; end
        3: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
        default: begin a = $urandom; b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'd1; end
      endcase
      run_op(a, b);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
